// File: rtl/regfile_dump_reader.sv
// Read-side register-file client: sweeps a register range through one read port,
// streams each word over valid/ready and keeps a running checksum of the words dumped.
module regfile_dump_reader #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] first_reg,
    input  logic [ADDR_WIDTH-1:0] last_reg,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [DATA_WIDTH-1:0] checksum
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        PRESENT
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] idx;
    logic [ADDR_WIDTH-1:0] last;
    logic                  handshake;
    logic                  range_ok;
    logic                  final_word;

    assign handshake  = out_valid && out_ready;
    assign range_ok   = first_reg <= last_reg;
    // Compare instead of incrementing past the end, so idx never wraps at 31.
    assign final_word = idx == last;

    assign rd_addr = (state == ISSUE || state == CAPTURE) ? idx : '0;
    assign busy    = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // in the design updates from the same pre-edge values.
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: next state gets a default before the case so no path leaves it
        // unassigned, which would infer a latch.
        state_nxt = state;
        unique case (state)
            IDLE:    if (start && range_ok) state_nxt = ISSUE;
            ISSUE:   state_nxt = abort ? IDLE : CAPTURE;
            CAPTURE: state_nxt = abort ? IDLE : PRESENT;
            PRESENT: begin
                if (abort)          state_nxt = IDLE;
                else if (handshake) state_nxt = final_word ? IDLE : ISSUE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            last      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            checksum  <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (range_ok) begin
                            idx      <= first_reg;
                            last     <= last_reg;
                            checksum <= '0;
                            error    <= 1'b0;
                        end else begin
                            done  <= 1'b1;
                            error <= 1'b1;
                        end
                    end
                end
                ISSUE: ;
                CAPTURE: begin
                    if (!abort) begin
                        out_data  <= rd_data;
                        out_index <= idx;
                        out_valid <= 1'b1;
                        checksum  <= checksum + rd_data;
                    end
                end
                PRESENT: begin
                    // Abort wins over a simultaneous handshake and suppresses done.
                    if (abort) begin
                        out_valid <= 1'b0;
                    end else if (handshake) begin
                        out_valid <= 1'b0;
                        if (final_word) done <= 1'b1;
                        else            idx  <= idx + 1'b1;
                    end
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: a register-file model answers reads,
// expected words are queued at stimulus time and a monitor checks each handshake.
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [4:0]  first_reg = '0;
    logic [4:0]  last_reg = '0;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [4:0]  out_index;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] checksum;

    typedef struct {
        logic [4:0]  index;
        logic [31:0] data;
    } word_t;

    word_t       exp_q[$];
    int          hs_cyc[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    logic [31:0] regs[32];

    regfile_dump_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .first_reg (first_reg),
        .last_reg  (last_reg),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    initial begin
        for (int k = 0; k < 32; k++) regs[k] = 32'(10 * k);
    end

    // Register file read port: data registered one cycle after the address.
    always @(posedge clk) begin
        rd_data <= regs[rd_addr];
        cyc     <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a word is consumed at the next rising edge when valid and ready are
    // high and abort is not overriding the handshake.
    always @(negedge clk) begin
        if (rst_n && done) done_cnt++;
        if (rst_n && out_valid && out_ready && !abort) begin
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_word: got index %0d data %0d, expected none", out_index, out_data);
            end else begin
                word_t w;
                w = exp_q.pop_front();
                check("word_index", 32'(out_index), 32'(w.index));
                check("word_data", out_data, w.data);
            end
        end
    end

    task automatic push_range(input int f, input int l);
        for (int k = f; k <= l; k++) begin
            word_t w;
            w.index = 5'(k);
            w.data  = 32'(10 * k);
            exp_q.push_back(w);
        end
    endtask

    task automatic do_start(input logic [4:0] f, input logic [4:0] l);
        first_reg = f;
        last_reg  = l;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (done) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL wait_done: got no done pulse, expected one within %0d cycles", budget);
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (out_valid) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL wait_valid: got no out_valid, expected one within %0d cycles", budget);
    endtask

    initial begin
        int          n;
        int          d0;
        logic [4:0]  ra;

        // Reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_error", 32'(error), 0);
        check("rst_checksum", checksum, 0);
        check("rst_rd_addr", 32'(rd_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Dump 1..3, ready held high: latency 2, then one word every 3 cycles
        hs_cyc.delete();
        d0 = done_cnt;
        push_range(1, 3);
        do_start(5'd1, 5'd3);
        wait_valid(10, n);
        check("first_valid_latency", 32'(n), 2);
        wait_done(30);
        check("d13_checksum", checksum, 60);
        check("d13_error", 32'(error), 0);
        repeat (4) @(posedge clk);
        #1;
        check("d13_done_pulses", 32'(done_cnt - d0), 1);
        check("d13_words", 32'(hs_cyc.size()), 3);
        if (hs_cyc.size() == 3) begin
            check("d13_gap1", 32'(hs_cyc[1] - hs_cyc[0]), 3);
            check("d13_gap2", 32'(hs_cyc[2] - hs_cyc[1]), 3);
        end

        // Full sweep 0..31
        hs_cyc.delete();
        d0 = done_cnt;
        push_range(0, 31);
        do_start(5'd0, 5'd31);
        wait_done(200);
        check("full_checksum", checksum, 4960);
        @(posedge clk);
        #1;
        check("full_busy_after_done", 32'(busy), 0);
        repeat (8) @(posedge clk);
        #1;
        check("full_words", 32'(hs_cyc.size()), 32);
        check("full_queue_empty", 32'(exp_q.size()), 0);
        check("full_done_pulses", 32'(done_cnt - d0), 1);

        // Backpressure: ready low for 5 cycles on the first word of 4..5
        out_ready = 1'b0;
        push_range(4, 5);
        do_start(5'd4, 5'd5);
        wait_valid(10, n);
        ra = rd_addr;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(out_valid), 1);
            check("stall_data", out_data, 40);
            check("stall_index", 32'(out_index), 4);
            check("stall_rd_addr", 32'(rd_addr), 32'(ra));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        wait_done(30);
        check("stall_checksum", checksum, 90);

        // Rejected range, then a valid start clears error
        repeat (2) @(posedge clk);
        #1;
        do_start(5'd5, 5'd2);
        check("rej_done", 32'(done), 1);
        check("rej_error", 32'(error), 1);
        check("rej_busy", 32'(busy), 0);
        check("rej_rd_addr", 32'(rd_addr), 0);
        @(posedge clk);
        #1;
        check("rej_done_single", 32'(done), 0);
        check("rej_busy_later", 32'(busy), 0);
        push_range(6, 6);
        do_start(5'd6, 5'd6);
        check("rej_error_cleared", 32'(error), 0);
        wait_done(30);
        check("rej_followup_checksum", checksum, 60);

        // Abort during the second PRESENT of 1..8; a start while busy is ignored
        repeat (2) @(posedge clk);
        #1;
        d0 = done_cnt;
        push_range(1, 1);
        do_start(5'd1, 5'd8);
        do_start(5'd20, 5'd20);
        n = 0;
        while (!(out_valid && out_index == 5'd2) && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("abort_reach_word2", 32'(n < 30), 1);
        check("abort_word2_data", out_data, 20);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_valid", 32'(out_valid), 0);
        check("abort_checksum", checksum, 30);
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done_cnt - d0), 0);
        check("abort_queue_empty", 32'(exp_q.size()), 0);

        // Asynchronous reset in the middle of CAPTURE
        do_start(5'd7, 5'd9);
        @(posedge clk);
        #1;
        check("pre_rst_rd_addr", 32'(rd_addr), 7);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_rd_addr", 32'(rd_addr), 0);
        check("arst_out_data", out_data, 0);
        check("arst_out_index", 32'(out_index), 0);
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_checksum", checksum, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_range(7, 7);
        do_start(5'd7, 5'd7);
        wait_done(30);
        check("single_checksum", checksum, 70);
        repeat (4) @(posedge clk);
        #1;
        check("final_queue_empty", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Read-side client of the 32x32 register file: on command, sweeps a contiguous register range through one register-file read port and streams each word out over a valid/ready interface.
- Tracks a running checksum of the dumped words.
- Sits between the register file and debug/trace logic: end-of-program state dump, or bench comparison against a golden model.
- Never drives the write port.

Parameters:
- ADDR_WIDTH, 5, register address width (32 registers).
- DATA_WIDTH, 32, register data width.

Ports:
- clk  in  1  system clock, all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a dump; sampled only in IDLE.
- abort  in  1  cancel an active dump.
- first_reg  in  ADDR_WIDTH  first register of range; captured at start.
- last_reg  in  ADDR_WIDTH  last register of range, inclusive; captured at start.
- rd_addr  out  ADDR_WIDTH  address to register-file read port (reg_read1/2).
- rd_data  in  DATA_WIDTH  registered read data from register file; valid one cycle after rd_addr is sampled.
- out_valid  out  1  out_data/out_index hold a word.
- out_ready  in  1  consumer accepts word when out_valid and out_ready are both high at a rising edge.
- out_data  out  DATA_WIDTH  dumped register value.
- out_index  out  ADDR_WIDTH  register number of out_data.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the range completes or is rejected.
- error  out  1  set with done when first_reg > last_reg; cleared on the next accepted start.
- checksum  out  DATA_WIDTH  sum mod 2^DATA_WIDTH of words dumped since the last accepted start.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - rd_addr, out_data, out_index, checksum = 0.
  - out_valid, busy, done, error = 0.
  - Reset mid-dump discards all progress; no done pulse is produced.
- States and transitions:
  - IDLE, start=1, first_reg<=last_reg: latch range, idx=first_reg, checksum=0, error=0, go to ISSUE.
  - IDLE, start=1, first_reg>last_reg: pulse done with error=1, stay in IDLE, no reads issued.
  - ISSUE: rd_addr=idx for this cycle; the register file samples it at the closing edge; go to CAPTURE.
  - CAPTURE: rd_data is valid. At the edge: out_data=rd_data, out_index=idx, out_valid=1, checksum+=rd_data (wraps mod 2^32); go to PRESENT.
  - PRESENT: out_valid=1, and out_data/out_index/checksum hold stable until the handshake.
    - On handshake with idx==last: out_valid=0, done=1 for one cycle, go to IDLE.
    - On handshake otherwise: out_valid=0, idx=idx+1, go to ISSUE.
- Latency:
  - start edge to first out_valid is 2 cycles.
  - With out_ready held high, throughput is 1 word per 3 cycles.
- rd_addr holds idx in ISSUE and CAPTURE, and is 0 in IDLE.
- Only one read is outstanding at a time, so no data is lost under backpressure.
- idx never wraps:
  - last_reg=31 ends after register 31.
  - The increment is skipped on the final word.
- first_reg==last_reg gives exactly one word.
- start while busy is ignored; first_reg/last_reg changes while busy have no effect.
- abort in ISSUE/CAPTURE/PRESENT: next edge goes to IDLE, out_valid=0, no done pulse, checksum keeps its partial value.
- abort and handshake in the same cycle: abort wins; no done pulse.
- abort in IDLE has no effect; an abort and start together in IDLE are treated as start.
- Register 0 is dumped like any other register (register file returns 0).

Test Plan:
- Preload register k = 10*k. Dump 1..3 with out_ready=1:
  - words (1,10),(2,20),(3,30);
  - first out_valid 2 cycles after start, then every 3 cycles;
  - done pulses once, checksum=60, error=0.
- Dump 0..31 with out_ready=1:
  - 32 words, index 0..31 in order, register 0 reads 0;
  - checksum=4960, busy deasserts after the done cycle, no index 0 after 31.
- Dump 4..5 with out_ready low 5 cycles on the first word:
  - out_valid stays high, out_data=40 and out_index=4 stable, no new rd_addr;
  - then 50 follows, checksum=90.
- first_reg=5, last_reg=2: done and error high the cycle after start, busy never asserts, rd_addr stays 0. A subsequent valid start clears error.
- Abort during the second PRESENT of dump 1..8: idle next cycle, no done pulse, checksum=30. start during busy is ignored.
- rst_n low mid-CAPTURE: all outputs zero immediately (asynchronous). After release, a dump 7..7 gives single word 70.
